// File: rtl/program_store_if.sv
// Loader and fetch handshakes of program_store, bundled into one interface.
// Latency: none, wires only.
// Backpressure: load_ready and rd_ready are the only stall signals seen by the driver.
interface program_store_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_last;
    logic                  load_ready;
    logic                  load_done;
    logic [ADDR_WIDTH:0]   load_count;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_oob;

    // Loader / CPU side.
    modport master (
        output load_start, load_valid, load_data, load_last, rd_req, rd_addr,
        input  load_ready, load_done, load_count, rd_ready, rd_valid, rd_data, rd_oob
    );

    // Program store side.
    modport slave (
        input  load_start, load_valid, load_data, load_last, rd_req, rd_addr,
        output load_ready, load_done, load_count, rd_ready, rd_valid, rd_data, rd_oob
    );
endinterface

// File: rtl/program_store.sv
// Loadable program memory: sequential image load from address 0, pipelined fetch port.
// Latency: fetch result LATENCY cycles after the accepting edge; load_done one cycle after the last word.
// Backpressure: rd_ready drops while an image is loading; load_ready is high only while loading.
module program_store #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DEPTH      = 256,
    parameter int                    LATENCY    = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input logic            clk,
    input logic            rst_n,
    program_store_if.slave bus
);
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  stg_vld [LATENCY];
    logic [DATA_WIDTH-1:0] stg_dat [LATENCY];
    logic                  stg_oob [LATENCY];

    logic                  load_fire;
    logic                  load_end;
    logic                  rd_fire;
    logic                  fetch_oob;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      wr_idx;

    assign bus.load_ready = (state == LOADING);
    assign bus.rd_ready   = (state != LOADING);

    assign load_fire = bus.load_valid && (state == LOADING);
    // An image ends on an explicit last word or when the array is full.
    assign load_end  = load_fire && (bus.load_last || (count_q == LAST_SLOT));
    assign rd_fire   = bus.rd_req && (state != LOADING);

    // Addresses outside the array are always past load_count, so the truncated
    // index is only ever used for in-image reads.
    assign rd_idx     = bus.rd_addr[IDX_W-1:0];
    assign wr_idx     = count_q[IDX_W-1:0];
    assign fetch_oob  = ({1'b0, bus.rd_addr} >= count_q);
    assign fetch_word = fetch_oob ? FILL_WORD : mem[rd_idx];

    // Load sequencing: state, image length and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                EMPTY, READY: begin
                    if (bus.load_start) begin
                        state   <= LOADING;
                        count_q <= '0;
                    end
                end
                LOADING: begin
                    if (load_fire) begin
                        count_q <= count_q + 1'b1;
                    end
                    if (load_end) begin
                        state  <= READY;
                        done_q <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Program array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[wr_idx] <= bus.load_data;
        end
    end

    // Fetch pipeline: read at accept into stage 0, later stages only shift.
    // Data/oob move only with a valid token so the outputs hold between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stg_vld[i] <= 1'b0;
                stg_dat[i] <= '0;
                stg_oob[i] <= 1'b0;
            end
        end else begin
            stg_vld[0] <= rd_fire;
            if (rd_fire) begin
                stg_dat[0] <= fetch_word;
                stg_oob[0] <= fetch_oob;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
                if (stg_vld[i-1]) begin
                    stg_dat[i] <= stg_dat[i-1];
                    stg_oob[i] <= stg_oob[i-1];
                end
            end
        end
    end

    assign bus.rd_valid   = stg_vld[LATENCY-1];
    assign bus.rd_data    = stg_dat[LATENCY-1];
    assign bus.rd_oob     = stg_oob[LATENCY-1];
    assign bus.load_done  = done_q;
    assign bus.load_count = count_q;
endmodule

// File: tb/tb_program_store.sv
// Bench for program_store: three instances (LATENCY 1, LATENCY 3, DEPTH 4) checked
// against an array/queue model of the image and the expected fetch results.
module tb_program_store;
    typedef struct packed {
        int         t;
        logic [7:0] d;
        logic       o;
    } ev_t;

    localparam logic [7:0] FILL_A = 8'h00;
    localparam logic [7:0] FILL_B = 8'h5A;
    localparam logic [7:0] FILL_C = 8'hC3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   done_a = 0, done_b = 0, done_c = 0;

    ev_t got_a[$], got_b[$], got_c[$];
    ev_t exp_a[$], exp_b[$], exp_c[$];

    // Reference image models: state 0 = empty, 1 = loading, 2 = ready.
    logic [7:0] m_mem [256];
    int         m_count = 0, m_state = 0, m_done = 0;
    logic [7:0] mc_mem [4];
    int         mc_count = 0, mc_state = 0, mc_done = 0;

    program_store_if ifa ();
    program_store_if ifb ();
    program_store_if ifc ();

    assign ifb.load_start = ifa.load_start;
    assign ifb.load_valid = ifa.load_valid;
    assign ifb.load_data  = ifa.load_data;
    assign ifb.load_last  = ifa.load_last;
    assign ifb.rd_req     = ifa.rd_req;
    assign ifb.rd_addr    = ifa.rd_addr;

    program_store #(.LATENCY(1), .FILL_WORD(FILL_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    program_store #(.LATENCY(3), .FILL_WORD(FILL_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    program_store #(.DEPTH(4), .LATENCY(1), .FILL_WORD(FILL_C)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse with the cycle it was visible in.
    always @(negedge clk) begin
        if (ifa.rd_valid) got_a.push_back(ev_t'({cyc, ifa.rd_data, ifa.rd_oob}));
        if (ifb.rd_valid) got_b.push_back(ev_t'({cyc, ifb.rd_data, ifb.rd_oob}));
        if (ifc.rd_valid) got_c.push_back(ev_t'({cyc, ifc.rd_data, ifc.rd_oob}));
        if (ifa.load_done) done_a++;
        if (ifb.load_done) done_b++;
        if (ifc.load_done) done_c++;
    end

    // Drive one cycle on the shared A/B port and advance the model (called at negedge).
    task automatic step_ab(input logic req, input logic [7:0] addr, input logic start,
                           input logic lv, input logic [7:0] ld, input logic ll);
        int acc;
        ifa.rd_req = req; ifa.rd_addr = addr; ifa.load_start = start;
        ifa.load_valid = lv; ifa.load_data = ld; ifa.load_last = ll;
        acc = cyc + 1;
        if (req && m_state != 1) begin
            if (int'(addr) < m_count) begin
                exp_a.push_back(ev_t'({acc, m_mem[addr], 1'b0}));
                exp_b.push_back(ev_t'({acc + 2, m_mem[addr], 1'b0}));
            end else begin
                exp_a.push_back(ev_t'({acc, FILL_A, 1'b1}));
                exp_b.push_back(ev_t'({acc + 2, FILL_B, 1'b1}));
            end
        end
        if (m_state != 1) begin
            if (start) begin m_state = 1; m_count = 0; end
        end else if (lv) begin
            m_mem[m_count] = ld;
            m_count++;
            if (ll || m_count == 256) begin m_state = 2; m_done++; end
        end
        @(negedge clk);
    endtask

    task automatic step_c(input logic req, input logic [7:0] addr, input logic start,
                          input logic lv, input logic [7:0] ld, input logic ll);
        int acc;
        ifc.rd_req = req; ifc.rd_addr = addr; ifc.load_start = start;
        ifc.load_valid = lv; ifc.load_data = ld; ifc.load_last = ll;
        acc = cyc + 1;
        if (req && mc_state != 1) begin
            if (int'(addr) < mc_count) exp_c.push_back(ev_t'({acc, mc_mem[addr], 1'b0}));
            else                       exp_c.push_back(ev_t'({acc, FILL_C, 1'b1}));
        end
        if (mc_state != 1) begin
            if (start) begin mc_state = 1; mc_count = 0; end
        end else if (lv) begin
            mc_mem[mc_count] = ld;
            mc_count++;
            if (ll || mc_count == 4) begin mc_state = 2; mc_done++; end
        end
        @(negedge clk);
    endtask

    // Results not yet visible when reset hits are lost.
    task automatic drop_inflight();
        ev_t keep[$];
        keep = {}; foreach (exp_a[i]) if (exp_a[i].t <= cyc) keep.push_back(exp_a[i]); exp_a = keep;
        keep = {}; foreach (exp_b[i]) if (exp_b[i].t <= cyc) keep.push_back(exp_b[i]); exp_b = keep;
        keep = {}; foreach (exp_c[i]) if (exp_c[i].t <= cyc) keep.push_back(exp_c[i]); exp_c = keep;
        m_state = 0; m_count = 0; mc_state = 0; mc_count = 0;
    endtask

    task automatic clear_queues();
        got_a.delete(); got_b.delete(); got_c.delete();
        exp_a.delete(); exp_b.delete(); exp_c.delete();
    endtask

    task automatic test_reset();
        ev_t g[$], e[$];
        logic [22:0] want;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        want = {1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 1'b1, 1'b0};
        checks++;
        if ({ifa.rd_valid, ifa.rd_data, ifa.rd_oob, ifa.load_done, ifa.load_count, ifa.rd_ready, ifa.load_ready} !== want) begin
            failures++; $display("FAIL reset_outputs_a got=%h want=%h", {ifa.rd_valid, ifa.rd_data, ifa.rd_oob, ifa.load_done, ifa.load_count, ifa.rd_ready, ifa.load_ready}, want);
        end
        checks++;
        if ({ifb.rd_valid, ifb.rd_data, ifb.rd_oob, ifb.load_done, ifb.load_count, ifb.rd_ready, ifb.load_ready} !== want) begin
            failures++; $display("FAIL reset_outputs_b got=%h want=%h", {ifb.rd_valid, ifb.rd_data, ifb.rd_oob, ifb.load_done, ifb.load_count, ifb.rd_ready, ifb.load_ready}, want);
        end
        checks++;
        if ({ifc.rd_valid, ifc.rd_data, ifc.rd_oob, ifc.load_done, ifc.load_count, ifc.rd_ready, ifc.load_ready} !== want) begin
            failures++; $display("FAIL reset_outputs_c got=%h want=%h", {ifc.rd_valid, ifc.rd_data, ifc.rd_oob, ifc.load_done, ifc.load_count, ifc.rd_ready, ifc.load_ready}, want);
        end
        step_ab(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (5) step_ab(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin g = got_a; e = exp_a; end else begin g = got_b; e = exp_b; end
            checks++;
            if (g.size() != e.size()) begin failures++; $display("FAIL empty_fetch_count[%0d] got=%0d want=%0d", k, g.size(), e.size()); end
            for (int i = 0; i < e.size(); i++) begin
                checks++;
                if (i >= g.size() || g[i] !== e[i]) begin failures++; $display("FAIL empty_fetch[%0d][%0d] got=%h want=%h", k, i, (i < g.size()) ? g[i] : '0, e[i]); end
            end
        end
        clear_queues();
    endtask

    task automatic test_load();
        ev_t g[$], e[$];
        logic [7:0] img [5];
        img = '{8'hB1, 8'h0A, 8'h82, 8'h44, 8'h9E};
        step_ab(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ifa.load_ready !== 1'b1 || ifa.rd_ready !== 1'b0) begin
                failures++; $display("FAIL load_handshake[%0d] got=%b%b want=10", i, ifa.load_ready, ifa.rd_ready);
            end
            step_ab(1'b0, 8'h00, 1'b0, 1'b1, img[i], i == 4);
        end
        checks++;
        if ({ifa.load_done, ifa.load_count, ifa.rd_ready, ifa.load_ready} !== {1'b1, 9'd5, 1'b1, 1'b0}) begin
            failures++; $display("FAIL load_end got=%b/%0d/%b/%b want=1/5/1/0", ifa.load_done, ifa.load_count, ifa.rd_ready, ifa.load_ready);
        end
        step_ab(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (ifa.load_done !== 1'b0) begin failures++; $display("FAIL load_done_pulse got=%b want=0", ifa.load_done); end
        step_ab(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) step_ab(1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (5) step_ab(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (done_a != m_done || done_b != m_done) begin failures++; $display("FAIL load_done_count got=%0d/%0d want=%0d", done_a, done_b, m_done); end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin g = got_a; e = exp_a; end else begin g = got_b; e = exp_b; end
            checks++;
            if (g.size() != e.size()) begin failures++; $display("FAIL load_fetch_count[%0d] got=%0d want=%0d", k, g.size(), e.size()); end
            for (int i = 0; i < e.size(); i++) begin
                checks++;
                if (i >= g.size() || g[i] !== e[i]) begin failures++; $display("FAIL load_fetch[%0d][%0d] got=%h want=%h", k, i, (i < g.size()) ? g[i] : '0, e[i]); end
            end
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        ev_t g[$], e[$];
        logic [7:0] last_d;
        for (int i = 0; i < 5; i++) step_ab(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 24; i++) step_ab(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 1'b0, 1'b0, 8'h00, 1'b0);
        step_ab(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (6) step_ab(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin g = got_a; e = exp_a; end else begin g = got_b; e = exp_b; end
            checks++;
            if (g.size() != e.size()) begin failures++; $display("FAIL b2b_count[%0d] got=%0d want=%0d", k, g.size(), e.size()); end
            for (int i = 0; i < e.size(); i++) begin
                checks++;
                if (i >= g.size() || g[i] !== e[i]) begin failures++; $display("FAIL b2b_fetch[%0d][%0d] got=%h want=%h", k, i, (i < g.size()) ? g[i] : '0, e[i]); end
            end
        end
        last_d = exp_b[exp_b.size() - 1].d;
        checks++;
        if (ifb.rd_valid !== 1'b0 || ifb.rd_data !== last_d || ifb.rd_oob !== 1'b0) begin
            failures++; $display("FAIL hold_last got=%b/%h/%b want=0/%h/0", ifb.rd_valid, ifb.rd_data, ifb.rd_oob, last_d);
        end
        clear_queues();
    endtask

    task automatic test_load_during_fetch();
        ev_t g[$], e[$];
        int n;
        step_ab(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (n < 4) begin
            logic lv;
            checks++;
            if (ifa.rd_ready !== 1'b0 || ifa.load_ready !== 1'b1) begin
                failures++; $display("FAIL reload_handshake got=%b%b want=01", ifa.rd_ready, ifa.load_ready);
            end
            lv = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            step_ab(1'b1, 8'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), lv,
                    (n == 0) ? 8'h11 : 8'($urandom), lv && n == 3);
            if (lv) n++;
        end
        for (int i = 0; i < 6; i++) step_ab(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (5) step_ab(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (ifa.load_count !== 9'd4 || done_a != m_done) begin
            failures++; $display("FAIL reload_count got=%0d/%0d want=4/%0d", ifa.load_count, done_a, m_done);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin g = got_a; e = exp_a; end else begin g = got_b; e = exp_b; end
            checks++;
            if (g.size() != e.size()) begin failures++; $display("FAIL reload_fetch_count[%0d] got=%0d want=%0d", k, g.size(), e.size()); end
            for (int i = 0; i < e.size(); i++) begin
                checks++;
                if (i >= g.size() || g[i] !== e[i]) begin failures++; $display("FAIL reload_fetch[%0d][%0d] got=%h want=%h", k, i, (i < g.size()) ? g[i] : '0, e[i]); end
            end
        end
        clear_queues();
    endtask

    task automatic test_depth_cap();
        step_c(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ifc.load_ready !== (mc_state == 1)) begin
                failures++; $display("FAIL cap_load_ready[%0d] got=%b want=%b", i, ifc.load_ready, mc_state == 1);
            end
            step_c(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom), 1'b0);
            if (i == 3) begin
                checks++;
                if (ifc.load_done !== 1'b1) begin failures++; $display("FAIL cap_done got=%b want=1", ifc.load_done); end
            end
        end
        checks++;
        if (ifc.load_count !== 9'd4 || ifc.load_ready !== 1'b0 || done_c != mc_done) begin
            failures++; $display("FAIL cap_state got=%0d/%b/%0d want=4/0/%0d", ifc.load_count, ifc.load_ready, done_c, mc_done);
        end
        for (int i = 0; i < 6; i++) step_c(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) step_c(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (got_c.size() != exp_c.size()) begin failures++; $display("FAIL cap_fetch_count got=%0d want=%0d", got_c.size(), exp_c.size()); end
        for (int i = 0; i < exp_c.size(); i++) begin
            checks++;
            if (i >= got_c.size() || got_c[i] !== exp_c[i]) begin failures++; $display("FAIL cap_fetch[%0d] got=%h want=%h", i, (i < got_c.size()) ? got_c[i] : '0, exp_c[i]); end
        end
        clear_queues();
    endtask

    task automatic test_reset_midload();
        ev_t g[$], e[$];
        step_ab(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        step_ab(1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0);
        step_ab(1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0);
        #1 rst_n = 1'b0;
        drop_inflight();
        #1;
        checks++;
        if ({ifa.load_count, ifa.load_ready, ifa.rd_ready, ifa.load_done, ifa.rd_valid} !== {9'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL midload_reset got=%0d/%b/%b/%b/%b want=0/0/1/0/0", ifa.load_count, ifa.load_ready, ifa.rd_ready, ifa.load_done, ifa.rd_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step_ab(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        step_ab(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        drop_inflight();
        #1;
        checks++;
        if ({ifb.rd_valid, ifb.rd_data, ifb.rd_oob, ifa.rd_valid, ifa.rd_data, ifa.rd_oob} !== 20'h0) begin
            failures++; $display("FAIL midfetch_reset got=%h want=0", {ifb.rd_valid, ifb.rd_data, ifb.rd_oob, ifa.rd_valid, ifa.rd_data, ifa.rd_oob});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) step_ab(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (ifb.load_count !== 9'd0 || ifb.rd_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_state got=%0d/%b want=0/1", ifb.load_count, ifb.rd_ready);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin g = got_a; e = exp_a; end else begin g = got_b; e = exp_b; end
            checks++;
            if (g.size() != e.size()) begin failures++; $display("FAIL reset_drop_count[%0d] got=%0d want=%0d", k, g.size(), e.size()); end
            for (int i = 0; i < e.size(); i++) begin
                checks++;
                if (i >= g.size() || g[i] !== e[i]) begin failures++; $display("FAIL reset_drop[%0d][%0d] got=%h want=%h", k, i, (i < g.size()) ? g[i] : '0, e[i]); end
            end
        end
        clear_queues();
    endtask

    initial begin
        ifa.rd_req = 1'b0; ifa.rd_addr = '0; ifa.load_start = 1'b0;
        ifa.load_valid = 1'b0; ifa.load_data = '0; ifa.load_last = 1'b0;
        ifc.rd_req = 1'b0; ifc.rd_addr = '0; ifc.load_start = 1'b0;
        ifc.load_valid = 1'b0; ifc.load_data = '0; ifc.load_last = 1'b0;
        test_reset();
        test_load();
        test_back_to_back();
        test_load_during_fetch();
        test_depth_cap();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
